// File: rtl/sha3_pkg.sv
// Shared types and constants for the parametrised SHA-3 padder.
// Rate constants assume W=64.
package sha3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        FULL,
        LASTFULL
    } pad_state_e;

    localparam logic [7:0] SHA3_DS   = 8'h06;
    localparam logic [7:0] KECCAK_DS = 8'h01;
    localparam logic [7:0] SHAKE_DS  = 8'h1F;

    localparam int unsigned RATE_224_W64 = 18;
    localparam int unsigned RATE_256_W64 = 17;
    localparam int unsigned RATE_384_W64 = 13;
    localparam int unsigned RATE_512_W64 = 9;

    // Out-of-range rates (0 or above the buffer depth) fall back to the full buffer.
    function automatic logic [4:0] clamp_rate(input logic [4:0] r, input int unsigned max_r);
        logic [31:0] max_v;
        max_v = max_r;
        if (r == 5'd0 || 32'(r) > max_v) begin
            return max_v[4:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/padder_byte_mask.sv
// Forms the final message word: keeps the valid leading bytes,
// inserts the domain-separation byte after them and zeroes the rest.
module padder_byte_mask #(
    parameter int unsigned W       = 64,
    parameter logic [7:0]  DS_BYTE = 8'h06
) (
    input  logic [W-1:0]           word_in,
    input  logic [$clog2(W/8)-1:0] byte_num,
    output logic [W-1:0]           word_out
);

    always_comb begin
        word_out = '0;
        for (int unsigned i = 0; i < W / 8; i++) begin
            if (i < 32'(byte_num)) begin
                word_out[W-1-8*i -: 8] = word_in[W-1-8*i -: 8];
            end else if (i == 32'(byte_num)) begin
                word_out[W-1-8*i -: 8] = DS_BYTE;
            end
        end
    end

endmodule

// File: rtl/padder_multi.sv
// Multi-rate SHA-3/Keccak padder: packs W-bit words into rate blocks,
// applies pad10*1 with a configurable DS byte and flags the final block.
module padder_multi
    import sha3_pkg::*;
#(
    parameter int unsigned W              = 64,
    parameter int unsigned MAX_RATE_WORDS = 18,
    parameter logic [7:0]  DS_BYTE        = SHA3_DS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [4:0]                  rate_words,
    input  logic [W-1:0]                in,
    input  logic                        in_ready,
    input  logic                        is_last,
    input  logic [$clog2(W/8)-1:0]      byte_num,
    output logic                        in_ack,
    output logic                        buffer_full,
    output logic [MAX_RATE_WORDS*W-1:0] out,
    output logic                        out_ready,
    output logic                        out_last,
    input  logic                        f_ack
);

    localparam int unsigned CW = $clog2(MAX_RATE_WORDS + 1);

    pad_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     rate_q, rate_d;
    logic [W-1:0]   buf_q [MAX_RATE_WORDS];
    logic [W-1:0]   buf_d [MAX_RATE_WORDS];

    logic [4:0]     rate_in;
    logic [4:0]     rate_cur;
    logic           at_end;
    logic           accept;
    logic [W-1:0]   last_word;
    logic [W-1:0]   wr_word;

    assign rate_in = clamp_rate(rate_words, MAX_RATE_WORDS);

    padder_byte_mask #(
        .W       (W),
        .DS_BYTE (DS_BYTE)
    ) u_byte_mask (
        .word_in  (in),
        .byte_num (byte_num),
        .word_out (last_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rate_d   = rate_q;
        buf_d    = buf_q;
        accept   = 1'b0;
        // The first accept of a message uses the live rate input, later words the latch.
        rate_cur = (state_q == IDLE) ? rate_in : rate_q;
        at_end   = (32'(cnt_q) + 32'd1 == 32'(rate_cur));
        wr_word  = is_last ? last_word : in;
        if (is_last && at_end) begin
            wr_word[W-1] = 1'b1;
        end

        case (state_q)
            IDLE, ABSORB: begin
                if (in_ready) begin
                    accept        = 1'b1;
                    buf_d[cnt_q]  = wr_word;
                    if (state_q == IDLE) begin
                        rate_d = rate_in;
                    end
                    if (at_end) begin
                        state_d = is_last ? LASTFULL : FULL;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = is_last ? PAD : ABSORB;
                    end
                end
            end
            PAD: begin
                buf_d[cnt_q]      = '0;
                buf_d[cnt_q][W-1] = at_end;
                if (at_end) begin
                    state_d = LASTFULL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FULL, LASTFULL: begin
                if (f_ack) begin
                    cnt_d   = '0;
                    buf_d   = '{default: '0};
                    state_d = (state_q == FULL) ? ABSORB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rate_q  <= '0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        out = '0;
        for (int unsigned k = 0; k < MAX_RATE_WORDS; k++) begin
            out[(MAX_RATE_WORDS-1-k)*W +: W] = buf_q[k];
        end
    end

    assign in_ack      = accept & reset;
    assign buffer_full = (state_q == FULL) || (state_q == LASTFULL);
    assign out_ready   = buffer_full;
    assign out_last    = (state_q == LASTFULL);

endmodule

// File: tb/tb_padder_multi.sv
// Directed self-checking bench for padder_multi at W=64, MAX_RATE_WORDS=18, DS=0x06.
module tb_padder_multi;

    localparam int unsigned W = 64;
    localparam int unsigned M = 18;

    logic           clk;
    logic           reset;
    logic [4:0]     rate_words;
    logic [W-1:0]   in_d;
    logic           in_ready;
    logic           is_last;
    logic [2:0]     byte_num;
    logic           in_ack;
    logic           buffer_full;
    logic [M*W-1:0] out_w;
    logic           out_ready;
    logic           out_last;
    logic           f_ack;

    int errors = 0;
    int checks = 0;
    int n_pad;

    padder_multi #(
        .W              (64),
        .MAX_RATE_WORDS (18),
        .DS_BYTE        (8'h06)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rate_words  (rate_words),
        .in          (in_d),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .in_ack      (in_ack),
        .buffer_full (buffer_full),
        .out         (out_w),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .f_ack       (f_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] wrd(input int unsigned k);
        return out_w[(M-1-k)*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] data, input logic last, input logic [2:0] bn);
        int n;
        in_d     = data;
        is_last  = last;
        byte_num = bn;
        in_ready = 1'b1;
        #1;
        n = 0;
        while (in_ack !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("ack_wait", 64'(in_ack), 64'd1);
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        is_last  = 1'b0;
    endtask

    task automatic wait_full(output int n);
        n = 0;
        while (buffer_full !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("full_wait", 64'(buffer_full), 64'd1);
    endtask

    task automatic pulse_ack();
        f_ack = 1'b1;
        @(posedge clk);
        #1;
        f_ack = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        rate_words = 5'd9;
        in_d       = '0;
        in_ready   = 1'b1;
        is_last    = 1'b0;
        byte_num   = '0;
        f_ack      = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_bfull", 64'(buffer_full), 64'd0);
        chk("rst_oready", 64'(out_ready), 64'd0);
        chk("rst_olast", 64'(out_last), 64'd0);
        chk("rst_inack", 64'(in_ack), 64'd0);
        chk("rst_out", 64'(|out_w), 64'd0);
        in_ready = 1'b0;
        reset    = 1'b1;
        tick();

        // 1: rate 9, last word at cnt 0 with byte_num 0
        rate_words = 5'd9;
        send_word(64'h0123_4567_89AB_CDEF, 1'b1, 3'd0);
        chk("t1_w0", wrd(0), 64'h0600_0000_0000_0000);
        chk("t1_bfull_early", 64'(buffer_full), 64'd0);
        wait_full(n_pad);
        chk("t1_pad_cycles", 64'(n_pad), 64'd8);
        chk("t1_olast", 64'(out_last), 64'd1);
        chk("t1_oready", 64'(out_ready), 64'd1);
        chk("t1_w1", wrd(1), 64'h0);
        chk("t1_w7", wrd(7), 64'h0);
        chk("t1_w8", wrd(8), 64'h8000_0000_0000_0000);
        chk("t1_w9", wrd(9), 64'h0);
        in_ready = 1'b1;
        #1;
        chk("t1_noack_full", 64'(in_ack), 64'd0);
        in_ready = 1'b0;
        pulse_ack();
        chk("t1_cleared", 64'(|out_w), 64'd0);
        chk("t1_bfull_after", 64'(buffer_full), 64'd0);

        // 2: rate 9, 8 full words then last word with byte_num 3 at word 8
        for (int i = 0; i < 8; i++) begin
            send_word(64'h1000_0000_0000_0000 | 64'(i), 1'b0, 3'd0);
        end
        send_word(64'hAABB_CCDD_EEFF_1122, 1'b1, 3'd3);
        chk("t2_bfull", 64'(buffer_full), 64'd1);
        chk("t2_olast", 64'(out_last), 64'd1);
        chk("t2_w0", wrd(0), 64'h1000_0000_0000_0000);
        chk("t2_w7", wrd(7), 64'h1000_0000_0000_0007);
        chk("t2_w8", wrd(8), 64'hAABB_CC06_0000_0000);
        pulse_ack();
        chk("t2_no_second", 64'(buffer_full), 64'd0);

        // 3: rate 17, 20 full words then last word with byte_num 7
        rate_words = 5'd17;
        for (int i = 0; i < 17; i++) begin
            send_word(64'hC000_0000_0000_0000 | 64'(i), 1'b0, 3'd0);
        end
        chk("t3_b1_full", 64'(buffer_full), 64'd1);
        chk("t3_b1_olast", 64'(out_last), 64'd0);
        chk("t3_b1_w0", wrd(0), 64'hC000_0000_0000_0000);
        chk("t3_b1_w16", wrd(16), 64'hC000_0000_0000_0010);
        in_d     = 64'hC000_0000_0000_0011;
        is_last  = 1'b0;
        in_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_noack", 64'(in_ack), 64'd0);
            chk("t3_hold_full", 64'(buffer_full), 64'd1);
            tick();
        end
        f_ack = 1'b1;
        #1;
        chk("t3_ack_cycle_noack", 64'(in_ack), 64'd0);
        @(posedge clk);
        #1;
        f_ack = 1'b0;
        #1;
        chk("t3_after_ack_bfull", 64'(buffer_full), 64'd0);
        chk("t3_after_ack_w0", wrd(0), 64'h0);
        chk("t3_after_ack_inack", 64'(in_ack), 64'd1);
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        chk("t3_b2_w0", wrd(0), 64'hC000_0000_0000_0011);
        send_word(64'hC000_0000_0000_0012, 1'b0, 3'd0);
        send_word(64'hC000_0000_0000_0013, 1'b0, 3'd0);
        send_word(64'h0102_0304_0506_0708, 1'b1, 3'd7);
        wait_full(n_pad);
        chk("t3_pad_cycles", 64'(n_pad), 64'd13);
        chk("t3_b2_olast", 64'(out_last), 64'd1);
        chk("t3_b2_w2", wrd(2), 64'hC000_0000_0000_0013);
        chk("t3_b2_w3", wrd(3), 64'h0102_0304_0506_0706);
        chk("t3_b2_w4", wrd(4), 64'h0);
        chk("t3_b2_w16", wrd(16), 64'h8000_0000_0000_0000);
        chk("t3_b2_w17", wrd(17), 64'h0);
        pulse_ack();

        // 4: back-to-back messages, rate_words switched mid-message
        rate_words = 5'd9;
        send_word(64'h2000_0000_0000_0000, 1'b0, 3'd0);
        rate_words = 5'd13;
        for (int i = 1; i < 8; i++) begin
            send_word(64'h2000_0000_0000_0000 | 64'(i), 1'b0, 3'd0);
        end
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0);
        chk("t4a_bfull", 64'(buffer_full), 64'd1);
        chk("t4a_olast", 64'(out_last), 64'd1);
        chk("t4a_w8", wrd(8), 64'h8600_0000_0000_0000);
        pulse_ack();
        send_word(64'h5555_5555_5555_5555, 1'b0, 3'd0);
        rate_words = 5'd9;
        send_word(64'hAB00_1122_3344_5566, 1'b1, 3'd1);
        wait_full(n_pad);
        chk("t4b_pad_cycles", 64'(n_pad), 64'd11);
        chk("t4b_w0", wrd(0), 64'h5555_5555_5555_5555);
        chk("t4b_w1", wrd(1), 64'hAB06_0000_0000_0000);
        chk("t4b_w8", wrd(8), 64'h0);
        chk("t4b_w12", wrd(12), 64'h8000_0000_0000_0000);
        chk("t4b_w13", wrd(13), 64'h0);
        chk("t4b_olast", 64'(out_last), 64'd1);
        pulse_ack();

        // 5: reset asserted while padding
        rate_words = 5'd17;
        send_word(64'h3333_3333_3333_3333, 1'b1, 3'd0);
        tick();
        tick();
        #1;
        reset    = 1'b0;
        in_ready = 1'b1;
        #1;
        chk("t5_rst_bfull", 64'(buffer_full), 64'd0);
        chk("t5_rst_out", 64'(|out_w), 64'd0);
        chk("t5_rst_inack", 64'(in_ack), 64'd0);
        #1;
        reset    = 1'b1;
        in_ready = 1'b0;
        tick();
        rate_words = 5'd9;
        send_word(64'h1122_3344_5566_7788, 1'b1, 3'd4);
        chk("t5_w0", wrd(0), 64'h1122_3344_0600_0000);
        wait_full(n_pad);
        chk("t5_pad_cycles", 64'(n_pad), 64'd8);
        chk("t5_w8", wrd(8), 64'h8000_0000_0000_0000);
        chk("t5_w16", wrd(16), 64'h0);
        pulse_ack();

        // 6: f_ack while not full, in_ready held during FULL
        f_ack = 1'b1;
        tick();
        f_ack = 1'b0;
        chk("t6_idle_bfull", 64'(buffer_full), 64'd0);
        rate_words = 5'd2;
        send_word(64'h4444_0000_0000_0001, 1'b0, 3'd0);
        pulse_ack();
        chk("t6_absorb_w0_kept", wrd(0), 64'h4444_0000_0000_0001);
        chk("t6_absorb_bfull", 64'(buffer_full), 64'd0);
        send_word(64'h4444_0000_0000_0002, 1'b0, 3'd0);
        chk("t6_full", 64'(buffer_full), 64'd1);
        chk("t6_full_olast", 64'(out_last), 64'd0);
        chk("t6_w1", wrd(1), 64'h4444_0000_0000_0002);
        in_ready = 1'b1;
        is_last  = 1'b1;
        byte_num = 3'd0;
        #1;
        chk("t6_full_noack", 64'(in_ack), 64'd0);
        in_ready = 1'b0;
        pulse_ack();
        send_word(64'h9999_9999_9999_9999, 1'b1, 3'd0);
        chk("t6_last_w0", wrd(0), 64'h0600_0000_0000_0000);
        wait_full(n_pad);
        chk("t6_pad_cycles", 64'(n_pad), 64'd1);
        chk("t6_last_w1", wrd(1), 64'h8000_0000_0000_0000);
        pulse_ack();

        // 7: rate 1 shares DS and pad bit; rate 0 clamps to 18
        rate_words = 5'd1;
        send_word(64'h1122_3344_5566_7788, 1'b1, 3'd2);
        chk("t7_r1_bfull", 64'(buffer_full), 64'd1);
        chk("t7_r1_olast", 64'(out_last), 64'd1);
        chk("t7_r1_w0", wrd(0), 64'h9122_0600_0000_0000);
        chk("t7_r1_w1", wrd(1), 64'h0);
        pulse_ack();
        rate_words = 5'd0;
        send_word(64'h7777_7777_7777_7777, 1'b1, 3'd0);
        wait_full(n_pad);
        chk("t7_r0_pad_cycles", 64'(n_pad), 64'd17);
        chk("t7_r0_w0", wrd(0), 64'h0600_0000_0000_0000);
        chk("t7_r0_w16", wrd(16), 64'h0);
        chk("t7_r0_w17", wrd(17), 64'h8000_0000_0000_0000);
        pulse_ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
